// File: rtl/sumador_pkg.sv
// ----------------------------------------------------------------------------
// sumador_pkg
//   Shared types for the bit-serial adder.
//   estado_t : controller state (IDLE waiting for start, SHIFT adding one bit
//              per clock, DONE presenting the result for one cycle).
// ----------------------------------------------------------------------------
package sumador_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } estado_t;

endpackage : sumador_pkg

// File: rtl/sumador_completo.sv
// ----------------------------------------------------------------------------
// sumador_completo
//   Single-bit combinational full adder; the only arithmetic cell of the
//   serial adder.
// Ports
//   a, b  in  : operand bits
//   cin   in  : carry in
//   s     out : sum bit      (a ^ b ^ cin)
//   cout  out : carry out    (majority of a, b, cin)
// ----------------------------------------------------------------------------
module sumador_completo (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : sumador_completo

// File: rtl/sumador_serial.sv
// ----------------------------------------------------------------------------
// sumador_serial
//   Bit-serial adder: S = A + B computed LSB first over WIDTH clocks with one
//   full-adder cell and a carry flip-flop. start/done handshake.
// Parameters
//   WIDTH     operand/result width, 2..32
// Ports
//   clk       in          rising-edge clock
//   rst_n     in          asynchronous active-low reset
//   start     in          request an addition (only honoured in IDLE)
//   a, b      in  WIDTH   operands, captured on the accepted start cycle
//   busy      out         high while additions are being shifted
//   done      out         one-cycle pulse, s/cout/overflow valid
//   s         out WIDTH   sum, held until the next accepted start
//   cout      out         carry out of bit WIDTH-1
//   overflow  out         signed overflow
// ----------------------------------------------------------------------------
module sumador_serial
   import sumador_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             overflow
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(WIDTH - 2);

   estado_t          estado_q, estado_d;
   logic [WIDTH-1:0] sh_a_q, sh_a_d;
   logic [WIDTH-1:0] sh_b_q, sh_b_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             carry_q, carry_d;
   logic             cmsb_q, cmsb_d;      // carry into the MSB, for overflow
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             fa_s;
   logic             fa_cout;

   sumador_completo u_fa (
      .a    (sh_a_q[0]),
      .b    (sh_b_q[0]),
      .cin  (carry_q),
      .s    (fa_s),
      .cout (fa_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q <= IDLE;
         sh_a_q   <= '0;
         sh_b_q   <= '0;
         s_q      <= '0;
         carry_q  <= 1'b0;
         cmsb_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         estado_q <= estado_d;
         sh_a_q   <= sh_a_d;
         sh_b_q   <= sh_b_d;
         s_q      <= s_d;
         carry_q  <= carry_d;
         cmsb_q   <= cmsb_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      estado_d = estado_q;
      sh_a_d   = sh_a_q;
      sh_b_d   = sh_b_q;
      s_d      = s_q;
      carry_d  = carry_q;
      cmsb_d   = cmsb_q;
      cnt_d    = cnt_q;

      case (estado_q)
         IDLE: begin
            if (start) begin
               sh_a_d   = a;
               sh_b_d   = b;
               carry_d  = 1'b0;
               cmsb_d   = 1'b0;
               cnt_d    = '0;
               estado_d = SHIFT;
            end
         end

         SHIFT: begin
            // Sum bits enter from the MSB side so that after WIDTH shifts
            // bit 0 of the result sits at s[0].
            s_d     = {fa_s, s_q[WIDTH-1:1]};
            sh_a_d  = sh_a_q >> 1;
            sh_b_d  = sh_b_q >> 1;
            carry_d = fa_cout;
            // Carry leaving bit WIDTH-2 is the carry into the MSB.
            if (cnt_q == CNT_PEN) begin
               cmsb_d = fa_cout;
            end
            // Counter stops at its last value instead of wrapping.
            if (cnt_q == CNT_LAST) begin
               estado_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         DONE: begin
            estado_d = IDLE;
         end

         default: begin
            estado_d = IDLE;
         end
      endcase
   end

   assign busy     = (estado_q == SHIFT);
   assign done     = (estado_q == DONE);
   assign s        = s_q;
   // carry_q keeps the final carry until the next start clears it.
   assign cout     = carry_q;
   assign overflow = carry_q ^ cmsb_q;

endmodule : sumador_serial
